// File: rtl/histogram_pkg.sv
// +----------------------------------------------------------------------------+
// | histogram_pkg : shared types and constants for the histogram peak reader     |
// | Optional feature macro: HIST_MOMENT_EN                                       |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

package histogram_pkg;

    localparam int X_BINS_DEF  = 240;
    localparam int Y_BINS_DEF  = 180;
    localparam int COUNT_W_DEF = 8;
    localparam int TIMEOUT_DEF = 1024;

    localparam int TOTAL_W    = 16;
    localparam int MOMENT_W   = 24;
    localparam int PEAK_BIN_W = 8;
    localparam int ERR_W      = 3;

    localparam int ERR_TIMEOUT  = 2;
    localparam int ERR_OVERRUN  = 1;
    localparam int ERR_MISMATCH = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_COLLECT  = 3'd2,
        ST_CLEAR    = 3'd3,
        ST_WAIT_CLR = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/histogram_peak_reader_if.sv
// +----------------------------------------------------------------------------+
// | histogram_peak_reader_if : readout bus and result bundle of the peak reader  |
// | Optional feature macro: HIST_MOMENT_EN (adds xMoment/yMoment)                |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

interface histogram_peak_reader_if #(
    parameter int COUNT_W = 8
);
    import histogram_pkg::*;

    logic                    go;
    logic                    filterDone;
    logic                    readHistogram;
    logic                    clearHistogram;
    logic [COUNT_W-1:0]      xHistogramIn;
    logic                    xValid;
    logic [COUNT_W-1:0]      yHistogramIn;
    logic                    yValid;
    logic                    histogramClear;
    logic [PEAK_BIN_W-1:0]   xPeakBin;
    logic [COUNT_W-1:0]      xPeakCount;
    logic [PEAK_BIN_W-1:0]   yPeakBin;
    logic [COUNT_W-1:0]      yPeakCount;
    logic [TOTAL_W-1:0]      xTotal;
    logic [TOTAL_W-1:0]      yTotal;
    logic                    resultValid;
    logic                    busy;
    logic [ERR_W-1:0]        error;
`ifdef HIST_MOMENT_EN
    logic [MOMENT_W-1:0]     xMoment;
    logic [MOMENT_W-1:0]     yMoment;

    modport master (
        input  go, filterDone, xHistogramIn, xValid, yHistogramIn, yValid, histogramClear,
        output readHistogram, clearHistogram, xPeakBin, xPeakCount, yPeakBin, yPeakCount,
               xTotal, yTotal, resultValid, busy, error, xMoment, yMoment
    );

    modport slave (
        output go, filterDone, xHistogramIn, xValid, yHistogramIn, yValid, histogramClear,
        input  readHistogram, clearHistogram, xPeakBin, xPeakCount, yPeakBin, yPeakCount,
               xTotal, yTotal, resultValid, busy, error, xMoment, yMoment
    );
`else
    modport master (
        input  go, filterDone, xHistogramIn, xValid, yHistogramIn, yValid, histogramClear,
        output readHistogram, clearHistogram, xPeakBin, xPeakCount, yPeakBin, yPeakCount,
               xTotal, yTotal, resultValid, busy, error
    );

    modport slave (
        output go, filterDone, xHistogramIn, xValid, yHistogramIn, yValid, histogramClear,
        input  readHistogram, clearHistogram, xPeakBin, xPeakCount, yPeakBin, yPeakCount,
               xTotal, yTotal, resultValid, busy, error
    );
`endif

endinterface

`default_nettype wire

// File: rtl/histogram_axis_reducer.sv
// +----------------------------------------------------------------------------+
// | histogram_axis_reducer : per-axis bin counter, peak tracker and accumulator  |
// | Optional feature macro: HIST_MOMENT_EN (index*count moment accumulator)      |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module histogram_axis_reducer
    import histogram_pkg::*;
#(
    parameter  int BINS    = X_BINS_DEF,
    parameter  int COUNT_W = COUNT_W_DEF,
    localparam int CNT_W   = $clog2(BINS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  valid_i,
    input  logic [COUNT_W-1:0]    data_i,
    output logic [CNT_W-1:0]      bin_cnt_o,
    output logic                  full_o,
    output logic [PEAK_BIN_W-1:0] peak_bin_o,
    output logic [COUNT_W-1:0]    peak_count_o,
    output logic [TOTAL_W-1:0]    total_o
`ifdef HIST_MOMENT_EN
    ,
    output logic [MOMENT_W-1:0]   moment_o
`endif
);

    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [PEAK_BIN_W-1:0] pbin_q,  pbin_d;
    logic [COUNT_W-1:0]    pcnt_q,  pcnt_d;
    logic [TOTAL_W-1:0]    total_q, total_d;
    logic                  w_full;
    logic                  w_accept;

    assign w_full   = (cnt_q == CNT_W'(BINS));
    assign w_accept = valid_i && !w_full;

    always_comb begin
        cnt_d   = cnt_q;
        pbin_d  = pbin_q;
        pcnt_d  = pcnt_q;
        total_d = total_q;
        if (clear_i) begin
            cnt_d   = '0;
            pbin_d  = '0;
            pcnt_d  = '0;
            total_d = '0;
        end else if (w_accept) begin
            cnt_d   = cnt_q + 1'b1;
            total_d = total_q + TOTAL_W'(data_i);
            // Strict compare keeps the lowest index on ties.
            if (data_i > pcnt_q) begin
                pcnt_d = data_i;
                pbin_d = PEAK_BIN_W'(cnt_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            pbin_q  <= '0;
            pcnt_q  <= '0;
            total_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            pbin_q  <= pbin_d;
            pcnt_q  <= pcnt_d;
            total_q <= total_d;
        end
    end

`ifdef HIST_MOMENT_EN
    logic [MOMENT_W-1:0] mom_q, mom_d;

    always_comb begin
        mom_d = mom_q;
        if (clear_i) begin
            mom_d = '0;
        end else if (w_accept) begin
            mom_d = mom_q + (MOMENT_W'(cnt_q) * MOMENT_W'(data_i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mom_q <= '0;
        end else begin
            mom_q <= mom_d;
        end
    end

    assign moment_o = mom_q;
`endif

    assign bin_cnt_o    = cnt_q;
    assign full_o       = w_full;
    assign peak_bin_o   = pbin_q;
    assign peak_count_o = pcnt_q;
    assign total_o      = total_q;

endmodule

`default_nettype wire

// File: rtl/histogram_peak_reader.sv
// +----------------------------------------------------------------------------+
// | histogram_peak_reader : requests a histogram dump, reduces it to per-axis    |
// | peak/total, clears the histogram. Optional macro: HIST_MOMENT_EN             |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module histogram_peak_reader
    import histogram_pkg::*;
#(
    parameter int X_BINS  = X_BINS_DEF,
    parameter int Y_BINS  = Y_BINS_DEF,
    parameter int COUNT_W = COUNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    histogram_peak_reader_if.master bus
);

    localparam int XC_W  = $clog2(X_BINS + 1);
    localparam int YC_W  = $clog2(Y_BINS + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [TMO_W-1:0]   tmo_q,   tmo_d;
    logic [ERR_W-1:0]   err_q,   err_d;

    logic [XC_W-1:0]    w_x_cnt;
    logic [YC_W-1:0]    w_y_cnt;
    logic               w_x_full, w_y_full;
    logic               w_collect, w_x_valid, w_y_valid;
    logic               w_x_last, w_y_last;
    logic               w_beat, w_tmo_hit, w_tmo_abort;

    assign w_collect = (state_q == ST_COLLECT);
    assign w_x_valid = w_collect && bus.xValid;
    assign w_y_valid = w_collect && bus.yValid;
    // Axis counts as complete in the cycle its final beat arrives.
    assign w_x_last  = w_x_full || (w_x_valid && (w_x_cnt == XC_W'(X_BINS - 1)));
    assign w_y_last  = w_y_full || (w_y_valid && (w_y_cnt == YC_W'(Y_BINS - 1)));
    assign w_beat    = bus.xValid || bus.yValid;
    assign w_tmo_hit = !w_beat && (tmo_q == TMO_W'(TIMEOUT - 1));

    histogram_axis_reducer #(.BINS(X_BINS), .COUNT_W(COUNT_W)) u_x_reducer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (state_q == ST_REQ),
        .valid_i      (w_x_valid),
        .data_i       (bus.xHistogramIn),
        .bin_cnt_o    (w_x_cnt),
        .full_o       (w_x_full),
        .peak_bin_o   (bus.xPeakBin),
        .peak_count_o (bus.xPeakCount),
        .total_o      (bus.xTotal)
`ifdef HIST_MOMENT_EN
        ,
        .moment_o     (bus.xMoment)
`endif
    );

    histogram_axis_reducer #(.BINS(Y_BINS), .COUNT_W(COUNT_W)) u_y_reducer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (state_q == ST_REQ),
        .valid_i      (w_y_valid),
        .data_i       (bus.yHistogramIn),
        .bin_cnt_o    (w_y_cnt),
        .full_o       (w_y_full),
        .peak_bin_o   (bus.yPeakBin),
        .peak_count_o (bus.yPeakCount),
        .total_o      (bus.yTotal)
`ifdef HIST_MOMENT_EN
        ,
        .moment_o     (bus.yMoment)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        w_tmo_abort = 1'b0;
        case (state_q)
            ST_IDLE:     if (bus.go && bus.filterDone) state_d = ST_REQ;
            ST_REQ:      state_d = ST_COLLECT;
            ST_COLLECT: begin
                if (w_x_last && w_y_last) begin
                    state_d = ST_CLEAR;
                end else if (w_tmo_hit) begin
                    state_d     = ST_DONE;
                    w_tmo_abort = 1'b1;
                end
            end
            ST_CLEAR:    state_d = bus.histogramClear ? ST_DONE : ST_WAIT_CLR;
            ST_WAIT_CLR: begin
                if (bus.histogramClear) begin
                    state_d = ST_DONE;
                end else if (w_tmo_hit) begin
                    state_d     = ST_DONE;
                    w_tmo_abort = 1'b1;
                end
            end
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tmo_d = tmo_q;
        if ((state_d != state_q) || w_beat) begin
            tmo_d = '0;
        end else if ((state_q == ST_COLLECT) || (state_q == ST_WAIT_CLR)) begin
            tmo_d = tmo_q + 1'b1;
        end

        err_d = err_q;
        if (state_q == ST_REQ) begin
            err_d = '0;
        end else begin
            if ((w_x_valid && w_x_full) || (w_y_valid && w_y_full)) err_d[ERR_OVERRUN] = 1'b1;
            if (w_tmo_abort) err_d[ERR_TIMEOUT] = 1'b1;
            // Totals are only compared after a complete, cleared dump.
            if (((state_q == ST_CLEAR) || (state_q == ST_WAIT_CLR)) && (state_d == ST_DONE)
                && !w_tmo_abort && (bus.xTotal != bus.yTotal)) begin
                err_d[ERR_MISMATCH] = 1'b1;
            end
        end
    end

    always_comb begin
        bus.readHistogram  = (state_q == ST_REQ);
        bus.clearHistogram = (state_q == ST_CLEAR);
        bus.resultValid    = (state_q == ST_DONE);
        bus.busy           = (state_q != ST_IDLE);
        bus.error          = err_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_histogram_peak_reader.sv
// +----------------------------------------------------------------------------+
// | tb_histogram_peak_reader : scoreboard bench with a bin-array reference model |
// | Moment outputs are checked when HIST_MOMENT_EN is defined                    |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_histogram_peak_reader;
    import histogram_pkg::*;

    localparam int XB  = 240;
    localparam int YB  = 180;
    localparam int CW  = 8;
    localparam int TMO = 1024;

    typedef struct {
        int     xbin, xcnt, xtot;
        int     ybin, ycnt, ytot;
        longint xmom, ymom;
        int     err;
        int     clears;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    histogram_peak_reader_if #(.COUNT_W(CW)) bus ();

    histogram_peak_reader #(
        .X_BINS(XB), .Y_BINS(YB), .COUNT_W(CW), .TIMEOUT(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   clr_cnt = 0;
    bit   pend_busy = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: peak = first bin holding the maximum count; only the first n beats count.
    function automatic void axis_model(input int d[$], input int n,
                                       output int bin, output int cnt,
                                       output int tot, output longint mom);
        int take;
        take = (d.size() < n) ? d.size() : n;
        cnt = 0; tot = 0; mom = 0; bin = 0;
        for (int i = 0; i < take; i++) begin
            tot += d[i];
            mom += longint'(i) * d[i];
            if (d[i] > cnt) cnt = d[i];
        end
        if (cnt > 0) begin
            for (int i = take - 1; i >= 0; i--) if (d[i] == cnt) bin = i;
        end
    endfunction

    function automatic exp_t model(input int xd[$], input int yd[$]);
        exp_t e;
        bit   stall, over;
        axis_model(xd, XB, e.xbin, e.xcnt, e.xtot, e.xmom);
        axis_model(yd, YB, e.ybin, e.ycnt, e.ytot, e.ymom);
        stall = (xd.size() < XB) || (yd.size() < YB);
        over  = (xd.size() > XB) || (yd.size() > YB);
        e.err = (stall ? 4 : 0) | (over ? 2 : 0) | ((!stall && e.xtot != e.ytot) ? 1 : 0);
        e.clears = stall ? 0 : 1;
        return e;
    endfunction

    // Monitor: compares every resultValid pulse against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.clearHistogram) clr_cnt++;
        if (bus.resultValid) begin
            if (sb.size() == 0) begin
                chk("unexpected resultValid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("xPeakBin",   bus.xPeakBin,   e.xbin);
                chk("xPeakCount", bus.xPeakCount, e.xcnt);
                chk("xTotal",     bus.xTotal,     e.xtot);
                chk("yPeakBin",   bus.yPeakBin,   e.ybin);
                chk("yPeakCount", bus.yPeakCount, e.ycnt);
                chk("yTotal",     bus.yTotal,     e.ytot);
                chk("error",      bus.error,      e.err);
                chk("clear pulses", clr_cnt,      e.clears);
`ifdef HIST_MOMENT_EN
                chk("xMoment",    bus.xMoment,    e.xmom);
                chk("yMoment",    bus.yMoment,    e.ymom);
`endif
            end
            clr_cnt   = 0;
            pend_busy = 1;
        end else if (pend_busy) begin
            chk("busy after result", bus.busy, 0);
            pend_busy = 0;
        end
    end

    // Histogram-side clear acknowledge with 0..3 cycles of delay (0 = same cycle).
    initial begin
        int d;
        bus.histogramClear = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.clearHistogram) begin
                d = $urandom_range(3, 0);
                repeat (d) @(negedge clk);
                bus.histogramClear = 1'b1;
                @(negedge clk);
                bus.histogramClear = 1'b0;
            end
        end
    end

    task automatic drive_x(input int d[$], input int gapmax);
        foreach (d[i]) begin
            repeat ($urandom_range(gapmax, 0)) @(negedge clk);
            bus.xValid = 1'b1;
            bus.xHistogramIn = CW'(d[i]);
            @(negedge clk);
            bus.xValid = 1'b0;
        end
    endtask

    task automatic drive_y(input int d[$], input int gapmax);
        foreach (d[i]) begin
            repeat ($urandom_range(gapmax, 0)) @(negedge clk);
            bus.yValid = 1'b1;
            bus.yHistogramIn = CW'(d[i]);
            @(negedge clk);
            bus.yValid = 1'b0;
        end
    endtask

    task automatic start_req();
        bit ok = 0;
        bus.filterDone = 1'b1;
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bus.readHistogram) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("readHistogram seen", ok, 1);
        @(negedge clk);
        chk("readHistogram single cycle", bus.readHistogram, 0);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 3 * TMO; k++) begin
            if (!bus.busy) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("return to idle", ok, 1);
        repeat (2) @(negedge clk);
    endtask

    // mode 0: independent gappy streams plus a stray go; 1: lockstep, last beats together; 2: X then Y
    task automatic run_txn(input int xd[$], input int yd[$], input int mode);
        sb.push_back(model(xd, yd));
        start_req();
        case (mode)
            0: fork
                   drive_x(xd, 2);
                   drive_y(yd, 2);
                   begin bus.go = 1'b1; @(negedge clk); bus.go = 1'b0; end
               join
            1: begin
                   for (int c = 0; c < XB; c++) begin
                       bus.xValid = 1'b1;
                       bus.xHistogramIn = CW'(xd[c]);
                       bus.yValid = (c >= XB - YB);
                       bus.yHistogramIn = (c >= XB - YB) ? CW'(yd[c - (XB - YB)]) : '0;
                       @(negedge clk);
                   end
                   bus.xValid = 1'b0;
                   bus.yValid = 1'b0;
               end
            default: begin
                   drive_x(xd, 1);
                   drive_y(yd, 1);
               end
        endcase
        wait_idle();
    endtask

    function automatic void fill_sum(ref int q[$], input int n, input int total);
        int a, b, amt;
        q = {};
        for (int i = 0; i < n; i++) q.push_back(total / n);
        for (int k = 0; k < 4 * n; k++) begin
            a = $urandom_range(n - 1, 0);
            b = $urandom_range(n - 1, 0);
            amt = $urandom_range(40, 0);
            if (q[a] >= amt && q[b] + amt <= 255 && a != b) begin
                q[a] -= amt;
                q[b] += amt;
            end
        end
    endfunction

    initial begin
        int xd[$];
        int yd[$];
        bus.go = 0; bus.filterDone = 0;
        bus.xValid = 0; bus.yValid = 0;
        bus.xHistogramIn = '0; bus.yHistogramIn = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset busy",        bus.busy,           0);
        chk("reset outputs",     {bus.readHistogram, bus.clearHistogram, bus.resultValid}, 0);
        chk("reset error",       bus.error,          0);
        chk("reset xTotal",      bus.xTotal,         0);
        chk("reset peaks",       {bus.xPeakBin, bus.yPeakBin, bus.xPeakCount, bus.yPeakCount}, 0);
        reset = 1'b0;
        @(negedge clk);

        bus.go = 1'b1;
        @(negedge clk);
        chk("go without filterDone ignored", bus.busy, 0);
        bus.go = 1'b0;
        @(negedge clk);

        // Ramp X against a flat Y with one spike
        xd = {}; yd = {};
        for (int i = 0; i < XB; i++) xd.push_back(i % 180);
        for (int i = 0; i < YB; i++) yd.push_back(i == 90 ? 200 : 1);
        run_txn(xd, yd, 0);

        // Tie on X resolves to the lower bin; all-zero Y reports bin 0
        xd = {}; yd = {};
        for (int i = 0; i < XB; i++) xd.push_back((i == 10 || i == 50) ? 77 : 0);
        for (int i = 0; i < YB; i++) yd.push_back(0);
        run_txn(xd, yd, 0);

        // Matching totals with coincident final beats, then off by one
        fill_sum(xd, XB, 21600);
        fill_sum(yd, YB, 21600);
        run_txn(xd, yd, 1);
        if (yd[0] < 255) yd[0] = yd[0] + 1; else yd[0] = yd[0] - 1;
        run_txn(xd, yd, 1);

        // Stall after 100 X beats
        xd = {}; yd = {};
        for (int i = 0; i < 100; i++) xd.push_back($urandom_range(255, 0));
        run_txn(xd, yd, 2);

        // One beat too many on X; the extra beat would otherwise become the peak
        xd = {}; yd = {};
        for (int i = 0; i < XB; i++) xd.push_back($urandom_range(200, 0));
        xd.push_back(255);
        for (int i = 0; i < YB; i++) yd.push_back($urandom_range(255, 0));
        run_txn(xd, yd, 2);

        // Reset mid-collect aborts with no result and no clear
        xd = {};
        for (int i = 0; i < 50; i++) xd.push_back($urandom_range(255, 1));
        start_req();
        drive_x(xd, 1);
        #2 reset = 1'b1;
        #1;
        chk("async reset busy",    bus.busy, 0);
        chk("async reset totals",  {bus.xTotal, bus.yTotal}, 0);
        chk("async reset peak",    {bus.xPeakBin, bus.xPeakCount}, 0);
        chk("async reset pulses",  {bus.readHistogram, bus.clearHistogram, bus.resultValid}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single nonzero bin: 100 * 5 moment
        xd = {}; yd = {};
        for (int i = 0; i < XB; i++) xd.push_back(i == 100 ? 5 : 0);
        for (int i = 0; i < YB; i++) yd.push_back(i == 30 ? 5 : 0);
        run_txn(xd, yd, 0);

        for (int t = 0; t < 2; t++) begin
            xd = {}; yd = {};
            for (int i = 0; i < XB; i++) xd.push_back($urandom_range(255, 0));
            for (int i = 0; i < YB; i++) yd.push_back($urandom_range(255, 0));
            run_txn(xd, yd, 0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
